// File: rtl/alu_operand_stage.sv
// ---------------------------------------------------------------------------
// alu_operand_stage
//   Registered operand-select stage sitting between decode and the ALU.
//   Builds the two ALU operands (DATA0/DATA1) and the store data for
//   OP, OP-IMM, LOAD, STORE, LUI and AUIPC, applies EX/MEM forwarding,
//   detects load-use hazards and presents a valid/ready handshake on both
//   sides. The output is a single pipeline register that holds under
//   backpressure.
//
// Optional feature macro: OPSEL_JUMP_EN
//   When defined, JAL/JALR produce DATA0=PC, DATA1=4 (link value), and JALR
//   additionally reports its target (f1 + sext(IMM)) on STORE_DATA and
//   takes part in rs1 forwarding / stall detection. When undefined, both
//   opcodes fall into the default (ALU_EN=0) path.
//
// Ports
//   CLK, RST                 clock, synchronous active-high reset
//   IN_VALID / IN_READY      decode-side handshake
//   OPCODE, FUNCT3           instruction fields
//   RS1, RS2, RS1_DATA, RS2_DATA  source indices and register-file data
//   PC, IMM, U_IMM           instruction address and pre-assembled immediates
//   EX_WB_EN, EX_IS_LOAD, EX_RD, EX_RD_DATA   EX-stage producer
//   MEM_WB_EN, MEM_RD, MEM_RD_DATA            MEM-stage producer
//   OUT_VALID / OUT_READY    ALU-side handshake
//   DATA0, DATA1, STORE_DATA, ALU_EN, OUT_FUNCT3  registered outputs
// ---------------------------------------------------------------------------

// Per-source forwarding mux. One instance per source operand.
module alu_operand_fwd #(
  parameter int XLEN = 32
) (
  input  logic [4:0]      rs,
  input  logic [XLEN-1:0] rs_data,
  input  logic            ex_wb_en,
  input  logic            ex_is_load,
  input  logic [4:0]      ex_rd,
  input  logic [XLEN-1:0] ex_rd_data,
  input  logic            mem_wb_en,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_rd_data,
  output logic [XLEN-1:0] fwd
);
  // EX is the younger producer, so it wins over MEM. A load in EX has no
  // data yet; that case is covered by the stall, not by forwarding.
  always_comb begin
    if (rs == 5'd0)
      fwd = '0;
    else if (ex_wb_en && !ex_is_load && (ex_rd == rs))
      fwd = ex_rd_data;
    else if (mem_wb_en && (mem_rd == rs))
      fwd = mem_rd_data;
    else
      fwd = rs_data;
  end
endmodule

module alu_operand_stage #(
  parameter int XLEN    = 32,
  parameter int IMM_W   = 12,
  parameter int UIMM_W  = 20,
  parameter int SHAMT_W = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [6:0]        OPCODE,
  input  logic [2:0]        FUNCT3,
  input  logic [4:0]        RS1,
  input  logic [4:0]        RS2,
  input  logic [XLEN-1:0]   RS1_DATA,
  input  logic [XLEN-1:0]   RS2_DATA,
  input  logic [XLEN-1:0]   PC,
  input  logic [IMM_W-1:0]  IMM,
  input  logic [UIMM_W-1:0] U_IMM,
  input  logic              EX_WB_EN,
  input  logic              EX_IS_LOAD,
  input  logic [4:0]        EX_RD,
  input  logic [XLEN-1:0]   EX_RD_DATA,
  input  logic              MEM_WB_EN,
  input  logic [4:0]        MEM_RD,
  input  logic [XLEN-1:0]   MEM_RD_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [XLEN-1:0]   DATA0,
  output logic [XLEN-1:0]   DATA1,
  output logic [XLEN-1:0]   STORE_DATA,
  output logic              ALU_EN,
  output logic [2:0]        OUT_FUNCT3
);
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
`ifdef OPSEL_JUMP_EN
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
`endif

  // Source operands as a packed array: index 0 = rs1, index 1 = rs2.
  logic [1:0][4:0]      src_idx;
  logic [1:0][XLEN-1:0] src_data;
  logic [1:0][XLEN-1:0] fwd;

  assign src_idx  = {RS2, RS1};
  assign src_data = {RS2_DATA, RS1_DATA};

  generate
    for (genvar g = 0; g < 2; g++) begin : g_fwd
      alu_operand_fwd #(.XLEN(XLEN)) u_fwd (
        .rs          (src_idx[g]),
        .rs_data     (src_data[g]),
        .ex_wb_en    (EX_WB_EN),
        .ex_is_load  (EX_IS_LOAD),
        .ex_rd       (EX_RD),
        .ex_rd_data  (EX_RD_DATA),
        .mem_wb_en   (MEM_WB_EN),
        .mem_rd      (MEM_RD),
        .mem_rd_data (MEM_RD_DATA),
        .fwd         (fwd[g])
      );
    end
  endgenerate

  // Immediates. Signed casts give sign extension to XLEN.
  logic [XLEN-1:0]         imm_sext;
  logic [UIMM_W+11:0]      u_raw;
  logic [XLEN-1:0]         u_sext;
  logic [XLEN-1:0]         shamt_ext;

  assign imm_sext  = XLEN'($signed(IMM));
  assign u_raw     = {U_IMM, 12'b0};
  assign u_sext    = XLEN'($signed(u_raw));
  assign shamt_ext = XLEN'(IMM[SHAMT_W-1:0]);

  // Next-state operand values and source usage.
  logic            use1, use2;
  logic            alu_en_d;
  logic [XLEN-1:0] data0_d, data1_d, store_d;

  always_comb begin
    use1     = 1'b0;
    use2     = 1'b0;
    alu_en_d = 1'b0;
    data0_d  = '0;
    data1_d  = '0;
    store_d  = '0;
    unique case (OPCODE)
      OPC_OP: begin
        use1 = 1'b1; use2 = 1'b1; alu_en_d = 1'b1;
        data0_d = fwd[0];
        data1_d = fwd[1];
      end
      OPC_OPIMM: begin
        use1 = 1'b1; alu_en_d = 1'b1;
        data0_d = fwd[0];
        if (FUNCT3 == 3'b001) begin
          data1_d = shamt_ext;
        end else if (FUNCT3 == 3'b101) begin
          // IMM[10] distinguishes SRAI from SRLI; the ALU reads it here.
          data1_d     = shamt_ext;
          data1_d[10] = IMM[10];
        end else begin
          data1_d = imm_sext;
        end
      end
      OPC_LOAD: begin
        use1 = 1'b1; alu_en_d = 1'b1;
        data0_d = fwd[0];
        data1_d = imm_sext;
      end
      OPC_STORE: begin
        use1 = 1'b1; use2 = 1'b1; alu_en_d = 1'b1;
        data0_d = fwd[0];
        data1_d = imm_sext;
        store_d = fwd[1];
      end
      OPC_LUI: begin
        alu_en_d = 1'b1;
        data1_d  = u_sext;
      end
      OPC_AUIPC: begin
        alu_en_d = 1'b1;
        data0_d  = PC;
        data1_d  = u_sext;
      end
`ifdef OPSEL_JUMP_EN
      OPC_JAL: begin
        alu_en_d = 1'b1;
        data0_d  = PC;
        data1_d  = XLEN'(4);
      end
      OPC_JALR: begin
        use1 = 1'b1; alu_en_d = 1'b1;
        data0_d = PC;
        data1_d = XLEN'(4);
        // Jump target rides on the store-data lane.
        store_d = fwd[0] + imm_sext;
      end
`endif
      default: begin
        // Unknown opcode: still accepted and passed on, ALU disabled.
      end
    endcase
  end

  // Load-use hazard: the load result is not available until after EX.
  logic stall;
  assign stall = IN_VALID && EX_WB_EN && EX_IS_LOAD && (EX_RD != 5'd0) &&
                 ((use1 && (EX_RD == RS1)) || (use2 && (EX_RD == RS2)));

  assign IN_READY = !stall && (!OUT_VALID || OUT_READY);

  logic accept;
  assign accept = IN_VALID && IN_READY;

  always_ff @(posedge CLK) begin
    if (RST) begin
      OUT_VALID  <= 1'b0;
      DATA0      <= '0;
      DATA1      <= '0;
      STORE_DATA <= '0;
      ALU_EN     <= 1'b0;
      OUT_FUNCT3 <= '0;
    end else if (accept) begin
      OUT_VALID  <= 1'b1;
      DATA0      <= data0_d;
      DATA1      <= data1_d;
      STORE_DATA <= store_d;
      ALU_EN     <= alu_en_d;
      OUT_FUNCT3 <= FUNCT3;
    end else if (OUT_READY) begin
      // Consumed with nothing new (or stalled): emit a bubble.
      OUT_VALID <= 1'b0;
    end
  end

endmodule
